// File: rtl/fab_local_endpoint_pkg.sv
// Shared types for the tile local-port endpoint: transaction/id/ready structs,
// injection direction and FSM state enums, and the XY routing helpers.
package fab_local_endpoint_pkg;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } t_tile_id;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
    } t_tile_trans;

    typedef struct packed {
        logic north_arb;
        logic east_arb;
        logic south_arb;
        logic west_arb;
        logic local_arb;
    } t_fab_ready;

    typedef enum logic [2:0] {
        EP_NORTH,
        EP_EAST,
        EP_SOUTH,
        EP_WEST,
        EP_LOCAL
    } t_ep_dir;

    typedef enum logic {
        EP_IDLE,
        EP_SEND
    } t_ep_state;

    // X is resolved before Y, so a packet never turns back from Y into X.
    function automatic t_ep_dir xy_dir(t_tile_id local_id, t_tile_id target);
        t_ep_dir dir;
        if (target.x > local_id.x) begin
            dir = EP_EAST;
        end else if (target.x < local_id.x) begin
            dir = EP_WEST;
        end else if (target.y > local_id.y) begin
            dir = EP_SOUTH;
        end else if (target.y < local_id.y) begin
            dir = EP_NORTH;
        end else begin
            dir = EP_LOCAL;
        end
        return dir;
    endfunction

    function automatic logic arb_ready(t_fab_ready rdy, t_ep_dir dir);
        logic r;
        case (dir)
            EP_NORTH: r = rdy.north_arb;
            EP_EAST:  r = rdy.east_arb;
            EP_SOUTH: r = rdy.south_arb;
            EP_WEST:  r = rdy.west_arb;
            default:  r = rdy.local_arb;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fab_local_endpoint_fifo.sv
// fab_ep_fifo: registered-storage FIFO of t_tile_trans with empty flag and
// occupancy count; the head entry is readable in the same cycle (no fall-through).
module fab_ep_fifo
    import fab_local_endpoint_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  t_tile_trans       wdata,
    input  logic              pop,
    output t_tile_trans       rdata,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    t_tile_trans      mem_q [DEPTH];
    t_tile_trans      mem_d [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fab_local_endpoint.sv
// Tile local-port endpoint: XY-routed inject path with one hold register, and
// an eject FIFO toward the core. Optional macro FAB_EP_LOOPBACK_EN short-circuits
// LOCAL-bound transactions straight into the eject FIFO.
module fab_local_endpoint
    import fab_local_endpoint_pkg::*;
#(
    parameter int unsigned EJECT_DEPTH = 4,
    parameter int unsigned TILE_ID_MSB = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  t_tile_id    local_tile_id,
    input  logic        core_req_valid,
    input  t_tile_trans core_req,
    output logic        core_req_ready,
    output logic        ep_req_valid,
    output t_tile_trans ep_req,
    input  t_fab_ready  router_ready,
    input  logic        router_rsp_valid,
    input  t_tile_trans router_rsp,
    output t_fab_ready  ep_ready,
    output logic        core_rsp_valid,
    output t_tile_trans core_rsp,
    input  logic        core_rsp_ready,
    output logic        eject_overflow
);

    localparam int unsigned CNT_W = $clog2(EJECT_DEPTH) + 1;

    t_ep_state        state_q, state_d;
    t_tile_trans      hold_q, hold_d;
    t_ep_dir          dir_q, dir_d;
    logic             overflow_q, overflow_d;

    logic [7:0]       req_tid;
    logic             fire;
    logic             req_ready_int;
    logic             send_valid;
    logic             lb_fire;

    logic [CNT_W-1:0] eject_count;
    logic             eject_empty;
    logic             eject_full;
    logic             push;
    t_tile_trans      push_data;
    logic             pop;

    assign req_tid    = core_req.address[TILE_ID_MSB -: 8];
    assign eject_full = (eject_count == CNT_W'(EJECT_DEPTH));

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        dir_d         = dir_q;
        fire          = 1'b0;
        req_ready_int = 1'b0;
        send_valid    = 1'b0;
        lb_fire       = 1'b0;
        case (state_q)
            EP_IDLE: begin
                req_ready_int = 1'b1;
                if (core_req_valid) begin
                    hold_d  = core_req;
                    dir_d   = xy_dir(local_tile_id, t_tile_id'(req_tid));
                    state_d = EP_SEND;
                end
            end
            EP_SEND: begin
`ifdef FAB_EP_LOOPBACK_EN
                // A router delivery owns the FIFO write port that cycle.
                if (dir_q == EP_LOCAL) begin
                    fire    = !eject_full && !router_rsp_valid;
                    lb_fire = fire;
                end else begin
                    fire       = arb_ready(router_ready, dir_q);
                    send_valid = 1'b1;
                end
`else
                fire       = arb_ready(router_ready, dir_q);
                send_valid = 1'b1;
`endif
                req_ready_int = fire;
                if (fire) begin
                    if (core_req_valid) begin
                        hold_d = core_req;
                        dir_d  = xy_dir(local_tile_id, t_tile_id'(req_tid));
                    end else begin
                        state_d = EP_IDLE;
                    end
                end
            end
            default: state_d = EP_IDLE;
        endcase
    end

    always_comb begin
        push       = (router_rsp_valid && !eject_full) || lb_fire;
        push_data  = lb_fire ? hold_q : router_rsp;
        overflow_d = overflow_q || (router_rsp_valid && eject_full);
        pop        = core_rsp_valid && core_rsp_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EP_IDLE;
            hold_q     <= '0;
            dir_q      <= EP_NORTH;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            dir_q      <= dir_d;
            overflow_q <= overflow_d;
        end
    end

    fab_ep_fifo #(
        .DEPTH (EJECT_DEPTH)
    ) u_eject_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (core_rsp),
        .empty (eject_empty),
        .count (eject_count)
    );

    // Ready outputs are held low for the whole reset window, even though the
    // idle state and empty FIFO would otherwise advertise space.
    assign core_req_ready = req_ready_int && rst;
    assign ep_ready       = t_fab_ready'({5{!eject_full && rst}});
    assign ep_req_valid   = send_valid;
    assign ep_req         = hold_q;
    assign core_rsp_valid = !eject_empty;
    assign eject_overflow = overflow_q;

endmodule

// File: doc/fab_local_endpoint.md
Name: fab_local_endpoint

Overview:
- Endpoint that attaches a core to a router's local port. Fills the local port that tiles currently tie off.
- Inject path: accepts core transactions, routes each by XY, and holds it until the target arbiter's ready bit is set.
- Eject path: buffers router deliveries in a small FIFO and presents them to the core with valid/ready.
- Sits inside each tile, between the core/IO and the router.

Parameters:
- EJECT_DEPTH, 4: eject FIFO entries (power of two, ≥2).
- TILE_ID_MSB, 31: MSB of the 8-bit target tile id inside t_tile_trans.address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low; reset asserted while rst=0.
- local_tile_id  in  t_tile_id  this tile's {x[3:0],y[3:0]}.
- core_req_valid  in  1  core transaction valid.
- core_req  in  t_tile_trans  core transaction.
- core_req_ready  out  1  endpoint accepts core_req.
- ep_req_valid  out  1  to router in_local_req_valid.
- ep_req  out  t_tile_trans  to router in_local_req.
- router_ready  in  t_fab_ready  from router out_local_ready; per-arbiter ready.
- router_rsp_valid  in  1  from router out_local_req_valid.
- router_rsp  in  t_tile_trans  from router out_local_req.
- ep_ready  out  t_fab_ready  to router in_local_ready.
- core_rsp_valid  out  1  eject entry available.
- core_rsp  out  t_tile_trans  head of eject FIFO.
- core_rsp_ready  in  1  core pops head.
- eject_overflow  out  1  sticky; delivery arrived while FIFO full.

Behaviour:
Reset values (rst=0):
- core_req_ready=0, ep_req_valid=0, ep_req='0, core_rsp_valid=0, core_rsp='0, eject_overflow=0.
- ep_ready='0.
- Inject FSM in IDLE; FIFO empty, pointers 0.
- In the first cycle after reset releases, core_req_ready=1 and ep_ready is all ones.
- Reset mid-operation discards the held transaction and all FIFO contents without emitting them.

Inject FSM (registered, one hold register):
- IDLE:
  - core_req_ready=1, ep_req_valid=0.
  - On core_req_valid, capture core_req, compute dir_q, go to SEND.
- SEND:
  - ep_req_valid=1, ep_req=hold register (stable until fire).
  - fire = router_ready.<dir_q>_arb.
  - core_req_ready = fire, so a new core_req is accepted in the same cycle as fire.
  - On fire with core_req_valid: recapture, recompute dir_q, stay in SEND (back-to-back, 1 txn/cycle).
  - On fire without core_req_valid: go to IDLE.
  - Without fire: hold everything; no timeout.
- Latency: core_req accept → ep_req_valid next cycle. Minimum transfer is 1 cycle after capture.

Direction compute (combinational on captured target tid=address[TILE_ID_MSB-:8]):
- tid.x > local.x → EAST.
- tid.x < local.x → WEST.
- Otherwise, tid.y > local.y → SOUTH.
- Otherwise, tid.y < local.y → NORTH.
- Otherwise → LOCAL.
- Comparisons are unsigned 4-bit.

Eject path:
- ep_ready: all five bits = !full, computed combinationally from the registered count.
- push = router_rsp_valid && !full.
- router_rsp_valid && full: drop the transaction and set eject_overflow (cleared only by reset).
- pop = core_rsp_valid && core_rsp_ready.
- core_rsp_valid = !empty; core_rsp = head entry (registered storage, so zero-cycle read of head).
- Simultaneous push and pop when full: push is not accepted, because ready was low. When empty: the pushed entry becomes visible next cycle; no fall-through.
- Count is $clog2(EJECT_DEPTH)+1 bits. Pointers wrap modulo EJECT_DEPTH.

Optional Feature:
- FAB_EP_LOOPBACK_EN defined:
  - A captured transaction with dir=LOCAL bypasses the router and is written directly into the eject FIFO.
  - fire = !full && !router_rsp_valid; the router delivery has priority that cycle.
  - ep_req_valid stays 0 for it.
- Undefined: LOCAL transactions go to the router and fire on router_ready.local_arb.

Decomposition:
- router_pkg additions:
  - t_ep_dir enum {EP_NORTH, EP_EAST, EP_SOUTH, EP_WEST, EP_LOCAL}.
  - t_ep_state enum {EP_IDLE, EP_SEND}.
  - Function xy_dir(t_tile_id local, t_tile_id target) returning t_ep_dir.
- Sub-module: fab_ep_fifo, a parameterized t_tile_trans FIFO with full/empty/count.
- FSM and routing logic stay in fab_local_endpoint.

Test Plan:
1. local=0x11, core sends target 0x31 with router_ready.east_arb=1 → ep_req_valid next cycle, fires that cycle, FSM returns to IDLE.
2. local=0x11, target 0x10, router_ready.north_arb=0 for 5 cycles then 1 → ep_req held stable 5 cycles and core_req_ready=0; fires on cycle 6.
3. Three back-to-back core_req to 0x21 with east_arb=1 → three consecutive ep_req_valid cycles, no bubble.
4. Router delivers 4 txns with core_rsp_ready=0 → ep_ready all zero after the 4th; a 5th router_rsp_valid sets eject_overflow=1. Pop 1 → ep_ready all ones next cycle; order preserved.
5. Assert rst=0 while in SEND with 2 FIFO entries → all outputs at reset values immediately (async); after release no stale ep_req_valid or core_rsp_valid.
6. With FAB_EP_LOOPBACK_EN, local=0x22, target 0x22 → ep_req_valid stays 0 and core_rsp_valid asserts 2 cycles after core accept. A simultaneous router_rsp_valid delays the loopback by 1 cycle.
